// File: rtl/uart_tx_slave.sv
// Bus-slave UART transmitter: CTRL/STATUS/TXDATA/BAUD registers, TX FIFO, 8N1 serializer.
// Bit period is latched per frame, so BAUD writes only affect later frames.
module uart_tx_slave #(
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_q, baud_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   period_q, period_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;

  logic push, push_ok, pop, full, empty, busy, bit_end;
  logic unused_bits;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != IDLE);
  assign bit_end = (cnt_q == period_q - 16'd1);
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16]};

  // Register writes and FIFO bookkeeping; a push into a full FIFO survives if the FSM pops on the same edge.
  always_comb begin
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    baud_d  = baud_q;
    push    = 1'b0;
    if (we_i) begin
      unique case (addr_i[3:2])
        2'd0: ctrl_d = wdata_i[1:0];
        2'd1: if (wdata_i[3]) ovf_d = 1'b0;
        2'd2: push = 1'b1;
        2'd3: baud_d = (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
        default: ;
      endcase
    end
    push_ok = push & (~full | pop);
    if (push & full & ~pop) ovf_d = 1'b1;
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = 1'b1;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_q[0] && !empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rptr_q];
          period_d = baud_q;
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + 16'd1;
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= CLK_DIV;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      period_q <= CLK_DIV;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= wdata_i[7:0];
  end

  always_comb begin
    rdata_o = '0;
    unique case (addr_i[3:2])
      2'd0:    rdata_o = {30'd0, ctrl_q};
      2'd1:    rdata_o = {23'd0, 5'(count_q), ovf_q, empty, full, busy};
      2'd3:    rdata_o = {16'd0, baud_q};
      default: rdata_o = '0;
    endcase
  end

  assign tx_o  = tx_q;
  assign irq_o = ctrl_q[1] & empty & ~busy;

endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed bench for uart_tx_slave: register table plus hand-written frame, FIFO and reset sequences.
module tb_uart_tx_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        tx_o;
  logic        irq_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  uart_tx_slave #(.CLK_DIV(16'd434), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Caller is at a negedge; the write lands on the next posedge and we return at the following negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  // Expected line level k negedges after the edge that made the frame's byte available.
  function automatic logic exp_frame(input int k, input logic [7:0] d, input int b);
    int j;
    if (k < 2) return 1'b1;
    j = k - 2;
    if (j < b) return 1'b0;
    j = j - b;
    if (j < 8 * b) return d[j / b];
    return 1'b1;
  endfunction

  task automatic capture(input int n, input int wr_k, input logic [7:0] d0, input int b0,
                         input logic [7:0] d1, input int b1, input int off,
                         output int tx_err, output int busy_n, output int irq_n);
    logic e;
    tx_err = 0; busy_n = 0; irq_n = 0;
    for (int k = 0; k < n; k++) begin
      if (k == wr_k) begin
        we_i = 1'b1; addr_i = 32'hC; wdata_i = 32'd8;
      end else addr_i = 32'h4;
      #1;
      e = (k < off) ? exp_frame(k, d0, b0) : exp_frame(k - off, d1, b1);
      if (tx_o !== e) tx_err++;
      if (k != wr_k && rdata_o[0] === 1'b1) busy_n++;
      if (irq_o === 1'b1) irq_n++;
      @(negedge clk);
      we_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int tx_err, busy_n, irq_n;

    vecs[0]  = '{1'b0, 32'h0, 32'h0,        32'h0,        32'h0,   1'b0};
    vecs[1]  = '{1'b0, 32'h0, 32'h0,        32'h4,        32'h4,   1'b0};
    vecs[2]  = '{1'b0, 32'h0, 32'h0,        32'hC,        32'h1B2, 1'b0};
    vecs[3]  = '{1'b1, 32'hC, 32'h0,        32'hC,        32'h1,   1'b0};
    vecs[4]  = '{1'b1, 32'hC, 32'hFFFF0004, 32'hC,        32'h4,   1'b0};
    vecs[5]  = '{1'b1, 32'h0, 32'hFFFFFFFE, 32'h0,        32'h2,   1'b1};
    vecs[6]  = '{1'b0, 32'h0, 32'h0,        32'h10,       32'h2,   1'b1};
    vecs[7]  = '{1'b0, 32'h0, 32'h0,        32'hFFFFFFF0, 32'h2,   1'b1};
    vecs[8]  = '{1'b1, 32'h0, 32'h0,        32'h0,        32'h0,   1'b0};
    vecs[9]  = '{1'b1, 32'h8, 32'h123456AB, 32'h8,        32'h0,   1'b0};
    vecs[10] = '{1'b0, 32'h0, 32'h0,        32'h4,        32'h10,  1'b0};
    vecs[11] = '{1'b1, 32'h8, 32'h11,       32'h4,        32'h20,  1'b0};
    vecs[12] = '{1'b1, 32'h8, 32'h22,       32'h4,        32'h30,  1'b0};
    vecs[13] = '{1'b1, 32'h8, 32'h33,       32'h4,        32'h42,  1'b0};
    vecs[14] = '{1'b1, 32'h8, 32'h44,       32'h4,        32'h4A,  1'b0};
    vecs[15] = '{1'b1, 32'h4, 32'hFFFFFFF7, 32'h4,        32'h4A,  1'b0};
    vecs[16] = '{1'b1, 32'h4, 32'h8,        32'h4,        32'h42,  1'b0};
    vecs[17] = '{1'b1, 32'h4, 32'hFFFFFFFF, 32'h4,        32'h42,  1'b0};
    vecs[18] = '{1'b1, 32'h0, 32'h2,        32'h0,        32'h2,   1'b0};

    rst = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_tx", {31'd0, tx_o}, 32'h1);

    foreach (vecs[i]) begin
      if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(vecs[i].raddr, r);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'd0, irq_o}, {31'd0, vecs[i].exp_irq});
    end

    // FIFO full: enable TX, then push on the same edge the FSM pops.
    bus_write(32'h0, 32'h3);
    bus_write(32'h8, 32'h77);
    bus_read(32'h4, r);
    check("push_on_pop_status", r, 32'h43);

    // Reset in DATA with a full queue; the coincident CTRL write must be dropped.
    repeat (10) @(negedge clk);
    rst = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h3;
    @(negedge clk);
    rst = 1'b0; we_i = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx_o}, 32'h1);
    bus_read(32'h4, r);  check("rst_status", r, 32'h4);
    bus_read(32'hC, r);  check("rst_baud", r, 32'h1B2);
    bus_read(32'h0, r);  check("rst_ctrl", r, 32'h0);

    // Single 0xA5 frame at BAUD=4.
    @(negedge clk);
    bus_write(32'hC, 32'd4);
    bus_write(32'h0, 32'h1);
    bus_write(32'h8, 32'hA5);
    capture(50, -1, 8'hA5, 4, 8'h00, 4, 1000, tx_err, busy_n, irq_n);
    check("a5_tx_errs", tx_err, 0);
    check("a5_busy_cycles", busy_n, 40);

    // BAUD change mid-frame: 40-cycle frame, then an 80-cycle frame.
    bus_write(32'h0, 32'h0);
    bus_write(32'h8, 32'h3C);
    bus_write(32'h8, 32'hC3);
    bus_write(32'h0, 32'h1);
    capture(130, 10, 8'h3C, 4, 8'hC3, 8, 41, tx_err, busy_n, irq_n);
    check("baudchg_tx_errs", tx_err, 0);
    check("baudchg_busy_cycles", busy_n, 119);
    bus_read(32'hC, r);  check("baudchg_readback", r, 32'h8);

    // Interrupt around a single frame.
    bus_write(32'hC, 32'd4);
    bus_write(32'h0, 32'h3);
    #1;
    check("irq_idle_empty", {31'd0, irq_o}, 32'h1);
    bus_read(32'h10, r); check("ctrl_alias_10", r, 32'h3);
    bus_read(32'h0, r);  check("ctrl_at_0", r, 32'h3);
    bus_write(32'h8, 32'h5A);
    capture(50, -1, 8'h5A, 4, 8'h00, 4, 1000, tx_err, busy_n, irq_n);
    check("irq_tx_errs", tx_err, 0);
    check("irq_high_cycles", irq_n, 9);
    check("irq_after_frame", {31'd0, irq_o}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
